// File: rtl/tone_pkg.sv
// Shared constants and types for tone_sequencer and its half-period counter.
// Optional build macro used by the top: TONE_SEQUENCER_DURATION_EN.
package tone_pkg;

  // Widest octave field a note_t can carry; the top's OCT_W must not exceed it.
  localparam int OCT_W_MAX = 8;

  // Half-period counts at 50 MHz for scale degrees Do..Do2.
  localparam logic [15:0] BASE_HALF [0:7] = '{
    16'hBAB9, 16'hA65D, 16'h9430, 16'h8BE9,
    16'h7CB8, 16'h6EF9, 16'h62F1, 16'h5D5D
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [OCT_W_MAX-1:0] oct;
    logic [2:0]           idx;
  } note_t;

endpackage

// File: rtl/half_period_counter.sv
// Counts cycles within one level of the square wave; strobes a toggle after
// i_half cycles and flags the toggle that ends a full period (high -> low).
module half_period_counter
  import tone_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_half,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_level,
  output logic             o_toggle,
  output logic             o_period_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;

  assign o_toggle     = i_en && (r_cnt == r_half - CNT_W'(1));
  assign o_period_end = o_toggle && i_level;

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_half <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_half <= i_half;
    end else if (!i_en || o_toggle) begin
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Note-request driven square-wave source with one pending slot; retunes only at
// period boundaries. Optional macro TONE_SEQUENCER_DURATION_EN adds per-note length.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int OCT_W    = 2,
  parameter int MIN_HALF = 2
) (
  input  logic               inclk,
  input  logic               rst,
  input  logic               en,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [2:0]         note_idx,
  input  logic [OCT_W-1:0]   note_oct,
`ifdef TONE_SEQUENCER_DURATION_EN
  input  logic [15:0]        note_dur,
  output logic               note_done,
`endif
  output logic               outclk,
  output logic               outclk_Not,
  output logic               active,
  output logic [3+OCT_W-1:0] cur_note
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_full;
  note_t            r_pend_note;
  note_t            r_cur_note;
  logic [CNT_W-1:0] r_pend_half;
  logic             r_outclk;

  logic             w_accept;
  logic             w_load;
  logic             w_run;
  logic             w_toggle;
  logic             w_period_end;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_shift;
  logic [CNT_W-1:0] w_half;

`ifdef TONE_SEQUENCER_DURATION_EN
  logic [15:0]      r_pend_dur;
  logic [15:0]      r_dur_cnt;
  logic             r_note_done;
  logic             w_expire;
`endif

  assign w_accept = note_valid && !r_pend_full;
  assign w_run    = (r_state == RUN);

  // Half-period is resolved at accept time so a swap only needs a register copy.
  assign w_base  = CNT_W'(BASE_HALF[note_idx]);
  assign w_shift = w_base >> note_oct;
  assign w_half  = (w_shift < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : w_shift;

  half_period_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .i_clk        (inclk),
    .i_rst        (rst),
    .i_half       (r_pend_half),
    .i_load       (w_load),
    .i_en         (w_run),
    .i_level      (r_outclk),
    .o_toggle     (w_toggle),
    .o_period_end (w_period_end)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
`ifdef TONE_SEQUENCER_DURATION_EN
    w_expire    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (en && r_pend_full) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_period_end) begin
          if (!en) begin
            w_state_nxt = IDLE;
          end else if (r_pend_full) begin
            w_load = 1'b1;
          end
`ifdef TONE_SEQUENCER_DURATION_EN
          else if (r_dur_cnt == 16'd1) begin
            w_state_nxt = IDLE;
            w_expire    = 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_full <= 1'b0;
      r_pend_note <= '0;
      r_pend_half <= '0;
      r_cur_note  <= '0;
      r_outclk    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Accept needs an empty slot and a load needs a full one, so they never coincide.
      if (w_accept) begin
        r_pend_full <= 1'b1;
        r_pend_note <= '{oct: OCT_W_MAX'(note_oct), idx: note_idx};
        r_pend_half <= w_half;
      end else if (w_load) begin
        r_pend_full <= 1'b0;
      end
      if (w_load) begin
        r_cur_note <= r_pend_note;
      end
      if (w_load || !w_run) begin
        r_outclk <= 1'b0;
      end else if (w_toggle) begin
        r_outclk <= ~r_outclk;
      end
    end
  end

`ifdef TONE_SEQUENCER_DURATION_EN
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      r_pend_dur  <= '0;
      r_dur_cnt   <= '0;
      r_note_done <= 1'b0;
    end else begin
      r_note_done <= w_expire;
      if (w_accept) begin
        r_pend_dur <= (note_dur == 16'd0) ? 16'd1 : note_dur;
      end
      if (w_load) begin
        r_dur_cnt <= r_pend_dur;
      end else if (w_period_end) begin
        r_dur_cnt <= r_dur_cnt - 16'd1;
      end
    end
  end

  assign note_done = r_note_done;
`endif

  assign note_ready = !r_pend_full;
  assign outclk     = r_outclk;
  assign outclk_Not = ~r_outclk;
  assign active     = w_run;
  assign cur_note   = (3+OCT_W)'(r_cur_note);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer (default build, OCT_W widened
// to 4 so the MIN_HALF clamp is reachable).
module tb_tone_sequencer;

  localparam int CNT_W    = 32;
  localparam int OCT_W    = 4;
  localparam int MIN_HALF = 2;

  logic               inclk = 1'b0;
  logic               rst;
  logic               en;
  logic               note_valid;
  logic               note_ready;
  logic [2:0]         note_idx;
  logic [OCT_W-1:0]   note_oct;
  logic               outclk;
  logic               outclk_Not;
  logic               active;
  logic [3+OCT_W-1:0] cur_note;
`ifdef TONE_SEQUENCER_DURATION_EN
  logic [15:0]        note_dur = 16'hFFFF;
  logic               note_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tone_sequencer #(
    .CNT_W    (CNT_W),
    .OCT_W    (OCT_W),
    .MIN_HALF (MIN_HALF)
  ) dut (
    .inclk      (inclk),
    .rst        (rst),
    .en         (en),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_idx   (note_idx),
    .note_oct   (note_oct),
`ifdef TONE_SEQUENCER_DURATION_EN
    .note_dur   (note_dur),
    .note_done  (note_done),
`endif
    .outclk     (outclk),
    .outclk_Not (outclk_Not),
    .active     (active),
    .cur_note   (cur_note)
  );

  always #10 inclk = ~inclk;

  task automatic tick(input int n);
    repeat (n) @(negedge inclk);
  endtask

  task automatic restart();
    note_valid = 1'b0;
    en         = 1'b1;
    rst        = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Presents a request and returns on the negedge after the transfer edge.
  task automatic send_note(input logic [2:0] idx, input logic [OCT_W-1:0] oct, output bit ok);
    note_idx   = idx;
    note_oct   = oct;
    note_valid = 1'b1;
    ok         = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (note_ready === 1'b1) ok = 1'b1;
      @(negedge inclk);
    end
    note_valid = 1'b0;
  endtask

  // Counts negedges until outclk reaches level; also watches the complement.
  task automatic measure(input logic level, input int limit, output int n, output bit inv_ok);
    n      = 0;
    inv_ok = 1'b1;
    do begin
      @(negedge inclk);
      n++;
      if (outclk_Not !== ~outclk) inv_ok = 1'b0;
    end while (outclk !== level && n < limit);
  endtask

  task automatic wait_active(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (active === 1'b1) ok = 1'b1;
      else @(negedge inclk);
    end
  endtask

  task automatic wait_note(input logic [3+OCT_W-1:0] want, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (cur_note === want) ok = 1'b1;
      else @(negedge inclk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; en = 1'b1; note_valid = 1'b0; note_idx = '0; note_oct = '0;
    tick(3);
    n_checks++; if (outclk_Not !== 1'b1 || note_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_during: outclk_Not=%b note_ready=%b want 1 1", outclk_Not, note_ready);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge inclk);
      if (outclk !== 1'b0 || outclk_Not !== 1'b1 || note_ready !== 1'b1 ||
          active !== 1'b0 || cur_note !== '0) bad++;
    end
    n_checks++; if (bad !== 0) begin
      n_fail++; $display("FAIL reset_idle_hold: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_single_note();
    bit ok, inv0, inv1; int n;
    restart();
    send_note(3'd0, 4'd3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept: not accepted"); end
    n_checks++; if (note_ready !== 1'b0 || active !== 1'b0) begin
      n_fail++; $display("FAIL single_pending: ready=%b active=%b want 0 0", note_ready, active);
    end
    tick(1);
    n_checks++; if (active !== 1'b1 || note_ready !== 1'b1 || cur_note !== 7'h18) begin
      n_fail++; $display("FAIL single_load: active=%b ready=%b cur=%h want 1 1 18", active, note_ready, cur_note);
    end
    measure(1'b1, 6100, n, inv0);
    n_checks++; if (n !== 5975) begin n_fail++; $display("FAIL single_first_rise: got %0d want 5975", n); end
    measure(1'b0, 6100, n, inv1);
    n_checks++; if (n !== 5975) begin n_fail++; $display("FAIL single_high: got %0d want 5975", n); end
    n_checks++; if (!(inv0 && inv1)) begin n_fail++; $display("FAIL single_complement: outclk_Not not inverse"); end
  endtask

  task automatic test_octave_shift();
    bit ok, inv; int n;
    restart();
    send_note(3'd7, 4'd3, ok);
    wait_active(10, ok);
    n_checks++; if (!ok || cur_note !== 7'h1F) begin
      n_fail++; $display("FAIL octave_note: active_ok=%b cur=%h want 1 1f", ok, cur_note);
    end
    measure(1'b1, 3100, n, inv);
    n_checks++; if (n !== 2987) begin n_fail++; $display("FAIL octave_low: got %0d want 2987", n); end
    measure(1'b0, 3100, n, inv);
    n_checks++; if (n !== 2987) begin n_fail++; $display("FAIL octave_high: got %0d want 2987", n); end
  endtask

  task automatic test_retune();
    bit ok, inv; int n;
    restart();
    send_note(3'd0, 4'd3, ok);
    wait_active(10, ok);
    measure(1'b1, 6100, n, inv);
    tick(1000);
    send_note(3'd4, 4'd3, ok);
    n_checks++; if (!ok || note_ready !== 1'b0) begin
      n_fail++; $display("FAIL retune_accept: ok=%b ready=%b want 1 0", ok, note_ready);
    end
    tick(100);
    n_checks++; if (note_ready !== 1'b0 || cur_note !== 7'h18) begin
      n_fail++; $display("FAIL retune_hold: ready=%b cur=%h want 0 18", note_ready, cur_note);
    end
    measure(1'b0, 5000, n, inv);
    n_checks++; if (n !== 4874) begin n_fail++; $display("FAIL retune_old_high: got %0d want 4874", n); end
    n_checks++; if (cur_note !== 7'h1C || note_ready !== 1'b1) begin
      n_fail++; $display("FAIL retune_swap: cur=%h ready=%b want 1c 1", cur_note, note_ready);
    end
    measure(1'b1, 4100, n, inv);
    n_checks++; if (n !== 3991) begin n_fail++; $display("FAIL retune_new_low: got %0d want 3991", n); end
    measure(1'b0, 4100, n, inv);
    n_checks++; if (n !== 3991) begin n_fail++; $display("FAIL retune_new_high: got %0d want 3991", n); end
  endtask

  task automatic test_back_pressure();
    bit ok, inv, ready_first; int n, xfers; logic [3+OCT_W-1:0] note_at;
    restart();
    send_note(3'd7, 4'd3, ok);
    wait_active(10, ok);
    send_note(3'd4, 4'd3, ok);
    note_idx = 3'd5; note_oct = 4'd3; note_valid = 1'b1;
    xfers = 0; note_at = '0; ready_first = note_ready;
    for (int i = 0; i < 20000 && xfers == 0; i++) begin
      if (note_ready === 1'b1) begin xfers++; note_at = cur_note; end
      @(negedge inclk);
    end
    note_valid = 1'b0;
    n_checks++; if (ready_first !== 1'b0) begin
      n_fail++; $display("FAIL bp_slot_full: ready=%b want 0", ready_first);
    end
    n_checks++; if (xfers !== 1 || note_at !== 7'h1C) begin
      n_fail++; $display("FAIL bp_transfer: xfers=%0d playing=%h want 1 1c", xfers, note_at);
    end
    n_checks++; if (note_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pending: ready=%b want 0", note_ready); end
    wait_note(7'h1D, 9000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_swap: cur=%h want 1d", cur_note); end
    measure(1'b1, 3700, n, inv);
    n_checks++; if (n !== 3551) begin n_fail++; $display("FAIL bp_new_low: got %0d want 3551", n); end
  endtask

  task automatic test_stop();
    bit ok, inv; int n, bad;
    restart();
    send_note(3'd7, 4'd3, ok);
    wait_active(10, ok);
    tick(1000);
    en = 1'b0;
    measure(1'b1, 3100, n, inv);
    n_checks++; if (n !== 1987 || active !== 1'b1) begin
      n_fail++; $display("FAIL stop_finish_low: got %0d active=%b want 1987 1", n, active);
    end
    measure(1'b0, 3100, n, inv);
    n_checks++; if (n !== 2987 || active !== 1'b0) begin
      n_fail++; $display("FAIL stop_finish_high: got %0d active=%b want 2987 0", n, active);
    end
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge inclk);
      if (active !== 1'b0 || outclk !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_stay_idle: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_rst_async();
    bit ok, inv; int n, bad;
    restart();
    send_note(3'd7, 4'd3, ok);
    wait_active(10, ok);
    send_note(3'd2, 4'd3, ok);
    measure(1'b1, 3100, n, inv);
    tick(500);
    n_checks++; if (outclk !== 1'b1 || note_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre: outclk=%b ready=%b want 1 0", outclk, note_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (outclk !== 1'b0 || outclk_Not !== 1'b1 || active !== 1'b0 ||
                    note_ready !== 1'b1 || cur_note !== '0) begin
      n_fail++; $display("FAIL rst_async: outclk=%b nOut=%b active=%b ready=%b cur=%h want 0 1 0 1 0",
                         outclk, outclk_Not, active, note_ready, cur_note);
    end
    @(negedge inclk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge inclk);
      if (active !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_pending_lost: %0d active cycles want 0", bad); end
  endtask

  task automatic test_min_clamp();
    bit ok, inv; int n;
    restart();
    send_note(3'd0, 4'd15, ok);
    wait_active(10, ok);
    measure(1'b1, 20, n, inv);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL clamp_low: got %0d want 2", n); end
    measure(1'b0, 20, n, inv);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL clamp_high: got %0d want 2", n); end
    send_note(3'd0, 4'd13, ok);
    wait_note(7'h68, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_swap: cur=%h want 68", cur_note); end
    measure(1'b1, 20, n, inv);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL shift13_low: got %0d want 5", n); end
    measure(1'b0, 20, n, inv);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL shift13_high: got %0d want 5", n); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_octave_shift();
    test_retune();
    test_back_pressure();
    test_stop();
    test_rst_async();
    test_min_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the single-octave switch-driven tone source.
- Accepts note requests (note index + octave) over a valid/ready handshake and buffers one pending note.
- Generates a square wave and its complement at 50 MHz.
- Retunes glitch-free, only at full-period boundaries; feeds the audio/codec output path of the iPod player.

Parameters:
- CNT_W, 32: width of the half-period counter and count arithmetic.
- OCT_W, 2: width of the octave field. Octave k divides the base half-period by 2^k.
- MIN_HALF, 2: lower clamp on the computed half-period count.

Ports:
- inclk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  playback enable
- note_valid  in  1  note request valid
- note_ready  out  1  pending slot free
- note_idx  in  3  scale degree, 0=Do .. 7=Do2
- note_oct  in  OCT_W  octave shift
- outclk  out  1  square-wave tone
- outclk_Not  out  1  inverse of outclk, always
- active  out  1  tone currently playing
- cur_note  out  3+OCT_W  {note_oct, note_idx} of the playing note

Behaviour:
- Base half-period counts, 0..7: 0xBAB9, 0xA65D, 0x9430, 0x8BE9, 0x7CB8, 0x6EF9, 0x62F1, 0x5D5D.
- half = max(base[idx] >> oct, MIN_HALF), computed in CNT_W bits at accept time and stored with the pending note.
- Reset values: outclk=0, outclk_Not=1, active=0, cur_note=0, note_ready=1. Pending slot empty, counter 0, state IDLE.
- Handshake:
  - Transfer occurs on a cycle where note_valid && note_ready.
  - note_ready = !pending_full (registered); there is no same-cycle bypass.
  - The slot frees on the cycle after it is consumed.
  - While the slot is full, a new request waits; nothing is overwritten.
- States:
  - IDLE: outclk=0, active=0, counter held at 0. If en && pending_full: load the pending note into the playing register, clear pending, counter=0, go to RUN.
  - RUN: the counter increments each cycle. When cnt == cur_half-1, toggle outclk and clear cnt. Each level therefore lasts exactly cur_half cycles, and the first rising edge comes cur_half cycles after load.
  - Period boundary = the cycle outclk toggles 1->0. At a period boundary:
    - if !en: go to IDLE, outclk=0;
    - else if pending_full: swap in the pending note, counter already 0, continue RUN;
    - else keep the current note.
- en deasserted mid-period: the current period completes, so there are no runt pulses.
- en reasserted in IDLE with the slot empty: remain in IDLE.
- Accept and swap in the same cycle: the pending note is consumed and note_ready rises on the next cycle.
- rst mid-tone: everything returns to reset values immediately (asynchronously); the pending note is lost.
- Counter wrap is impossible because cur_half ≤ 0xBAB9 < 2^CNT_W.

Optional Feature:
- Macro: TONE_SEQUENCER_DURATION_EN.
- When defined:
  - Adds input note_dur[15:0], captured with the note; a value of 0 is treated as 1.
  - A period down-counter is loaded on note start and decrements at each period boundary.
  - When it reaches 0 with no pending note, go to IDLE, outclk=0.
  - A pending note at that boundary swaps in as normal.
  - Adds output note_done: a 1-cycle pulse on the cycle playback ends due to expiry.
- When undefined: notes sustain until replaced or until en drops; no note_dur or note_done ports.

Decomposition:
- Package tone_pkg holds:
  - the BASE_HALF[0:7] constant array;
  - the state enum (IDLE, RUN);
  - a note_t typedef {oct, idx}.
- One natural sub-module: half_period_counter. It takes a loadable half count, a load strobe and an enable, and produces a toggle and a period_end strobe.
- The top level holds the handshake, the pending slot and the FSM.

Test Plan:
- Reset: rst high 3 cycles then low, en=1, no request -> outclk=0, outclk_Not=1, note_ready=1, active=0 held for 1000 cycles.
- Single note: idx=0, oct=0 -> first rise 0xBAB9 cycles after load; high 47801, low 47801; outclk_Not is always the inverse.
- Octave shift: idx=7, oct=3 -> half = 0x5D5D>>3 = 2987 cycles per level; cur_note={3,7}.
- Retune: while idx=0 plays, send idx=4 mid-high-phase -> current period completes unaltered; next period has 0x7CB8-cycle levels; note_ready low from accept to swap+1.
- Back-pressure: with the slot full, hold note_valid with idx=5 -> not accepted until the slot frees; exactly one transfer recorded.
- Stop/reset: drop en mid-low-phase -> the period finishes, then IDLE with outclk=0. Separately, assert rst mid-high-phase -> outclk=0 and active=0 in the same cycle (async).
